// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and helpers for the divide sequencer: op encoding, FSM states,
// signed-overflow dividend constants and small operand-prep functions.
package div_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_RESP  = 3'd4,
    ST_DRAIN = 3'd5
  } div_state_t;

  // Most-negative dividends as they appear after operand prep (MIN32 is sign-extended).
  localparam logic [63:0] DIV_MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] DIV_MIN32 = 64'hFFFF_FFFF_8000_0000;

  function automatic logic op_is_signed(input div_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/div_seq_ctrl_post_fix.sv
// Combinational result fix-up: restores quotient/remainder signs, selects the
// requested half and sign-extends the low word for W forms.
module div_post_fix
  import div_seq_ctrl_pkg::*;
(
  input  logic [63:0] q,
  input  logic [63:0] r,
  input  logic        sa,
  input  logic        sb,
  input  div_op_t     op,
  input  logic        word,
  output logic [63:0] res
);

  logic [63:0] q_fix;
  logic [63:0] r_fix;
  logic [63:0] sel;

  // Quotient sign follows sa^sb; remainder takes the dividend's sign.
  always_comb begin
    q_fix = (sa ^ sb) ? neg64(q) : q;
    r_fix = sa ? neg64(r) : r;
    sel   = op_is_rem(op) ? r_fix : q_fix;
    res   = word ? sext32(sel[31:0]) : sel;
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer around the unsigned iterative divider: operand prep, one-shot issue,
// result capture and sign/width fix-up; result held until out_ready.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic              in_word,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic              div_valid,
  output logic [XLEN-1:0]   div_a,
  output logic [XLEN-1:0]   div_b,
  input  logic              div_done,
  input  logic [2*XLEN-1:0] div_c
);

  div_state_t  state_q, state_d;
  div_op_t     op_q, op_d;
  logic        word_q, word_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [63:0] div_a_q, div_a_d;
  logic [63:0] div_b_q, div_b_d;
  logic [63:0] out_data_q, out_data_d;

  div_op_t     in_op_e;
  logic        in_sgn;
  logic [63:0] a_prep, b_prep;
  logic        a_neg, b_neg;
  logic [63:0] a_abs, b_abs;
  logic        b_zero, sovf, fast;

  logic [63:0] pf_q, pf_r, pf_res;
  logic        pf_sa, pf_sb, pf_word;
  div_op_t     pf_op;

  always_comb begin
    in_op_e = div_op_t'(in_op);
    in_sgn  = op_is_signed(in_op_e);
    if (in_word) begin
      a_prep = in_sgn ? sext32(in_a[31:0]) : {32'd0, in_a[31:0]};
      b_prep = in_sgn ? sext32(in_b[31:0]) : {32'd0, in_b[31:0]};
    end else begin
      a_prep = in_a;
      b_prep = in_b;
    end
    a_neg  = in_sgn & a_prep[63];
    b_neg  = in_sgn & b_prep[63];
    a_abs  = a_neg ? neg64(a_prep) : a_prep;
    b_abs  = b_neg ? neg64(b_prep) : b_prep;
    b_zero = (b_prep == 64'd0);
    sovf   = in_sgn && (b_prep == '1) && (a_prep == (in_word ? DIV_MIN32 : DIV_MIN64));
    fast   = b_zero | sovf;
  end

  // Shared fix-up: fast-path constants while idle, latched core result in CAPT.
  // Fast paths pass sa=sb=0 because their results are already correctly signed.
  always_comb begin
    if (state_q == ST_IDLE) begin
      pf_q    = b_zero ? '1 : a_prep;
      pf_r    = b_zero ? a_prep : 64'd0;
      pf_sa   = 1'b0;
      pf_sb   = 1'b0;
      pf_op   = in_op_e;
      pf_word = in_word;
    end else begin
      pf_q    = div_c[63:0];
      pf_r    = div_c[127:64];
      pf_sa   = sa_q;
      pf_sb   = sb_q;
      pf_op   = op_q;
      pf_word = word_q;
    end
  end

  div_post_fix u_post_fix (
    .q    (pf_q),
    .r    (pf_r),
    .sa   (pf_sa),
    .sb   (pf_sb),
    .op   (pf_op),
    .word (pf_word),
    .res  (pf_res)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    word_d     = word_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    out_data_d = out_data_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    div_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          op_d   = in_op_e;
          word_d = in_word;
          sa_d   = a_neg;
          sb_d   = b_neg;
          if (fast) begin
            out_data_d = pf_res;
            state_d    = ST_RESP;
          end else begin
            div_a_d = a_abs;
            div_b_d = b_abs;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        div_valid = 1'b1;
        state_d   = flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (flush)         state_d = ST_DRAIN;
        else if (div_done) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        // The core's result register is only guaranteed valid in this cycle.
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          out_data_d = pf_res;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        out_valid = 1'b1;
        if (flush || out_ready) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (div_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_DIV;
      word_q     <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      div_a_q    <= 64'd0;
      div_b_q    <= 64'd0;
      out_data_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      word_q     <= word_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      out_data_q <= out_data_d;
    end
  end

  assign div_a    = div_a_q;
  assign div_b    = div_b_q;
  assign out_data = out_data_q;

endmodule
